shreg_seq_ctrl: RTL

- Sequencing controller for the 16-bit hold/clear/load/shift register slice in the lgsynth91 register-datapath family.
- Owns the state register and accepts commands (CLEAR, LOAD, SHIFT-by-N) over a valid/ready handshake.
- Drives the per-cycle hold/clear/load/shift selects into the slice's next-state logic and reports completion.
- Sits between a command source (bench or upper FSM) and the register slice; the slice's inverted-output convention is preserved on q_n.

---
 rtl/shreg_pkg.sv | 27 ++
 rtl/shreg_seq_ctrl_if.sv | 30 +++
 rtl/shreg_next.sv | 26 ++
 rtl/shreg_seq_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared types for the shift-register sequencing controller and its next-state slice.
// Op, FSM state and slice-select encodings live here so bench and RTL agree on them.
package shreg_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = 5;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_CLEAR = 2'd1,
    OP_LOAD  = 2'd2,
    OP_SHIFT = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_CLEAR = 2'd1,
    SEL_LOAD  = 2'd2,
    SEL_SHIFT = 2'd3
  } sel_e;

endpackage

// File: rtl/shreg_seq_ctrl_if.sv
// Command channel into the sequencing controller: valid/ready with op, load data and shift count.
// The source drives the master side; the controller consumes on the slave side.
interface shreg_seq_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_cnt;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_cnt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_cnt,
    output cmd_ready
  );

endinterface

// File: rtl/shreg_next.sv
// Combinational next-state function of the hold/clear/load/shift register slice.
// Zero latency; no flow control, the select alone decides the next register value.
module shreg_next
  import shreg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  sel_e             sel,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (sel)
      SEL_HOLD:  q_next = q;
      SEL_CLEAR: q_next = '0;
      SEL_LOAD:  q_next = cmd_data;
      SEL_SHIFT: q_next = {q[WIDTH-2:0], ser_in};
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/shreg_seq_ctrl.sv
// Sequencing controller for the shift-register slice: CLEAR/LOAD/NOP finish in one cycle,
// SHIFT-by-N occupies N cycles with cmd_ready low; done (and aborted) pulse for one cycle.
module shreg_seq_ctrl
  import shreg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  shreg_seq_ctrl_if.slave  cmd,
  input  logic             ser_in,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  sel_e             sel;
  op_e              op;
  logic             accept;
  logic [CNT_W-1:0] cnt_sat;

  assign op            = op_e'(cmd.cmd_op);
  assign cmd.cmd_ready = (state_q == ST_IDLE) && rst_n;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign cnt_sat       = (cmd.cmd_cnt > CNT_MAX) ? CNT_MAX : cmd.cmd_cnt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel       = SEL_HOLD;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_CLEAR: begin
              sel    = SEL_CLEAR;
              done_d = 1'b1;
            end
            OP_LOAD: begin
              sel    = SEL_LOAD;
              done_d = 1'b1;
            end
            OP_SHIFT: begin
              if (cnt_sat == '0) begin
                done_d = 1'b1;
              end else begin
                state_d = ST_SHIFT;
                cnt_d   = cnt_sat;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      ST_SHIFT: begin
        // abort wins over the shift due on the same edge
        if (abort) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (cnt_q != '0) begin
          sel   = SEL_SHIFT;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  shreg_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .sel     (sel),
    .q       (q_q),
    .cmd_data(cmd.cmd_data),
    .ser_in  (ser_in),
    .q_next  (q_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      q_q       <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign q       = q_q;
  assign q_n     = ~q_q;
  assign ser_out = q_q[WIDTH-1];
  assign busy    = (state_q == ST_SHIFT);
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule
